// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: state encoding and perf counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload holding register with load enable; one instance per buffer slot.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load.
module pipe_entry_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Take the new payload only when loaded, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    // Payload storage, cleared to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic 2-entry (main + skid) pipeline stage with registered in_ready and synchronous flush.
// Latency: 1 cycle from input transfer to out_valid when empty; full throughput when streaming.
// Backpressure: in_ready drops (registered) once both slots hold data; optional stall counter under PIPE_SKID_PERF_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

    state_t           state_d;
    state_t           state_q;
    logic             out_valid_d;
    logic             out_valid_q;
    logic             in_ready_d;
    logic             in_ready_q;
    logic             main_load;
    logic             skid_load;
    logic [WIDTH-1:0] main_din;
    logic [WIDTH-1:0] main_dout;
    logic [WIDTH-1:0] skid_dout;

    // Next state, slot load controls and the registered handshake outputs.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_din  = in_data;
        unique case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (in_valid && out_ready) begin
                    main_load = 1'b1;
                end else if (!in_valid && out_ready) begin
                    state_d = EMPTY;
                end else if (in_valid && !out_ready) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                // in_data is ignored here; the skid entry drains into main first.
                if (out_ready) begin
                    main_din  = skid_dout;
                    main_load = 1'b1;
                    state_d   = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush overrides everything; any payload loaded this cycle is unreachable.
        if (flush) begin
            state_d = EMPTY;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    // State and handshake output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    pipe_entry_reg #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .rst_n (reset),
        .load  (main_load),
        .d     (main_din),
        .q     (main_dout)
    );

    pipe_entry_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_dout)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_dout;

`ifdef PIPE_SKID_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_d;
    logic [PERF_CNT_W-1:0] stall_cnt_q;

    // Count cycles where downstream refuses valid data, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {PERF_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, backpressure, flush, async reset, stall counter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised by holding out_ready low with both slots filled.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef PIPE_SKID_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_skid_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // Reset held for three cycles.
        tick(); tick(); tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_data",  out_data,           32'h0);
`ifdef PIPE_SKID_PERF_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

        // Single transfer.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        out_ready = 1'b1;
        tick();
        check("single_valid", {31'b0, out_valid}, 32'd1);
        check("single_data",  out_data,           32'hA5A5_0001);
        in_valid = 1'b0;
        tick();
        check("single_drain", {31'b0, out_valid}, 32'd0);

        // Streaming 16 words back to back.
        in_valid = 1'b1;
        in_data  = 32'd0;
        tick();
        for (int i = 1; i < 16; i++) begin
            check("stream_valid", {31'b0, out_valid}, 32'd1);
            check("stream_data",  out_data,           32'(i - 1));
            check("stream_ready", {31'b0, in_ready},  32'd1);
            in_data = 32'(i);
            tick();
        end
        check("stream_last", out_data, 32'd15);
        in_valid = 1'b0;
        tick();
        check("stream_empty", {31'b0, out_valid}, 32'd0);

        // Backpressure: fill both slots.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        check("bp_busy_valid", {31'b0, out_valid}, 32'd1);
        check("bp_busy_data",  out_data,           32'h11);
        check("bp_busy_ready", {31'b0, in_ready},  32'd1);
        in_data = 32'h22;
        tick();
        check("bp_full_ready", {31'b0, in_ready}, 32'd0);
        check("bp_full_data",  out_data,          32'h11);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;   // must be ignored while full
        tick();
        check("bp_hold_data",  out_data,           32'h11);
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_ready", {31'b0, in_ready},  32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_pop2_data",  out_data,           32'h22);
        check("bp_pop2_valid", {31'b0, out_valid}, 32'd1);
        check("bp_pop_ready",  {31'b0, in_ready},  32'd1);
        tick();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Flush with full buffer and a concurrent input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        tick();
        in_data = 32'h55;
        tick();
        check("fl_full_ready", {31'b0, in_ready}, 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h33;
        tick();
        check("fl_valid", {31'b0, out_valid}, 32'd0);
        check("fl_ready", {31'b0, in_ready},  32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_33", {31'b0, out_valid}, 32'd0);
        end

        // Asynchronous reset while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h66;
        tick();
        in_data = 32'h77;
        tick();
        check("ar_full_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check("ar_in_ready",  {31'b0, in_ready},  32'd1);
        check("ar_out_data",  out_data,           32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_after_valid", {31'b0, out_valid}, 32'd0);

        // Hold one valid entry under backpressure for 7 cycles, then flush.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h88;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("st_valid", {31'b0, out_valid}, 32'd1);
        check("st_data",  out_data,           32'h88);
`ifdef PIPE_SKID_PERF_EN
        check("st_cnt7", stall_cnt, 32'd7);
`endif
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("st_flush_valid", {31'b0, out_valid}, 32'd0);
`ifdef PIPE_SKID_PERF_EN
        check("st_cnt_kept", stall_cnt, 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Elastic pipeline stage register between two CPU pipeline stages, e.g. IF/ID or ID/EX.
- Valid/ready handshake on both sides; a 2-entry buffer (main + skid) gives full throughput.
- in_ready is a registered signal, which breaks the combinational ready path from downstream back to upstream.
- Synchronous flush squashes in-flight data for branch or exception redirects.

Parameters:
- WIDTH, 32, bit width of the data payload carried through the stage.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous squash; discards all buffered entries.
- in_valid  input  1  upstream has data on in_data.
- in_ready  output  1  stage can accept data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  downstream payload (main entry).

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Reset (reset=0, async): state EMPTY, out_valid=0, in_ready=1, out_data=0, skid entry=0.
- State machine, state_t: EMPTY (no entries), BUSY (main valid), FULL (main + skid valid).
- Registered outputs: out_valid = (state != EMPTY); in_ready = (state != FULL).
- EMPTY: in_valid -> main<=in_data, go BUSY. Otherwise stay.
- BUSY:
  - in_valid & out_ready -> main<=in_data, stay BUSY (1/cycle throughput).
  - !in_valid & out_ready -> go EMPTY.
  - in_valid & !out_ready -> skid<=in_data, go FULL.
  - !in_valid & !out_ready -> hold.
- FULL: in_ready=0; in_data ignored. out_ready -> main<=skid, go BUSY. Otherwise hold.
- Latency: in_data accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when EMPTY.
- Ordering: strictly FIFO. Never drop or duplicate an accepted entry except on flush.
- Stability: while out_valid & !out_ready, out_data and out_valid must not change, unless flush is asserted.
- Flush has the highest priority:
  - next state EMPTY, regardless of in_valid/out_ready.
  - An input transfer in the flush cycle is discarded.
  - out_valid=0 and in_ready=1 from the next cycle.
- Data retention: out_data retains its last value when EMPTY. Data is don't-care when out_valid=0; the bench must not check it.
- Reset mid-operation: immediate return to reset values; buffered entries are lost.
- Illegal state encoding: recover to EMPTY.

Optional Feature:
- Macro: PIPE_SKID_PERF_EN.
- Defined:
  - Adds port stall_cnt, output, 32 bits.
  - Counts cycles with out_valid & !out_ready. Saturates at 32'hFFFF_FFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] state_t {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - localparam PERF_CNT_W = 32.
- Sub-module pipe_entry_reg: WIDTH-bit register with load enable and async active-low reset to 0. Instantiated twice (main, skid).

Test Plan (WIDTH=32):
- Reset, then single transfer:
  - Hold reset=0 for 3 cycles -> out_valid=0, in_ready=1, out_data=0.
  - Release reset, drive in_valid=1, in_data=32'hA5A5_0001 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=32'hA5A5_0001; following cycle out_valid=0.
- Streaming: out_ready=1, push 16 back-to-back words 0..15 -> out_data emits 0..15 on consecutive cycles, in_ready stays 1, no gaps.
- Backpressure:
  - Push 32'h11, 32'h22 on consecutive cycles with out_ready=0 -> FULL, in_ready=0, out_data=32'h11 stable.
  - Raise out_ready -> 32'h11 then 32'h22 out, in_ready=1 one cycle after the first pop.
- Flush with full buffer: assert flush in FULL state, with in_valid=1 and in_data=32'h33 -> next cycle out_valid=0, in_ready=1; 32'h33 never appears on the output.
- Async reset in FULL state: drop reset mid-cycle -> out_valid=0 and in_ready=1 immediately, without a clock edge.
- PIPE_SKID_PERF_EN: hold out_valid with out_ready=0 for 7 cycles -> stall_cnt=7; then flush -> stall_cnt remains 7.
